// File: rtl/nibble_serial_adder_if.sv
// Bus bundle between the nibble serial adder and its controller.
// The controller drives the operands and the start level. The adder returns its registered result and status.
interface nibble_serial_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             run;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             load;
    logic             cout;
    logic             ovf;
    logic             busy;

    modport master (
        output run, a, b,
        input  sum, load, cout, ovf, busy
    );

    modport slave (
        input  run, a, b,
        output sum, load, cout, ovf, busy
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// Adds two captured operands one SLICE-bit slice per clock, LSB slice first.
// The final result is held on sum, and load pulses for one cycle so that reg_16 can latch it.
module nibble_serial_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    nibble_serial_adder_if.slave bus
);
    localparam int unsigned N  = WIDTH / SLICE;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StAdd, StDone, StHold} state_e;

    state_e                  r_state, w_state_next;
    logic [N-1:0][SLICE-1:0] r_op_a, w_op_a_next;
    logic [N-1:0][SLICE-1:0] r_op_b, w_op_b_next;
    logic [N-1:0][SLICE-1:0] r_sum, w_sum_next;
    logic [CW-1:0]           r_cnt, w_cnt_next;
    logic                    r_carry, w_carry_next;
    logic                    r_cout, w_cout_next;
    logic                    r_ovf, w_ovf_next;
    logic [SLICE:0]          w_slice;
    logic                    w_last;

    // Bit SLICE of w_slice holds the carry into the next slice.
    assign w_slice = {1'b0, r_op_a[r_cnt]} + {1'b0, r_op_b[r_cnt]} + {{SLICE{1'b0}}, r_carry};
    assign w_last  = (r_cnt == CW'(N - 1));

    always_comb begin
        w_state_next = r_state;
        w_op_a_next  = r_op_a;
        w_op_b_next  = r_op_b;
        w_sum_next   = r_sum;
        w_cnt_next   = r_cnt;
        w_carry_next = r_carry;
        w_cout_next  = r_cout;
        w_ovf_next   = r_ovf;

        unique case (r_state)
            StIdle: begin
                if (bus.run) begin
                    w_op_a_next  = bus.a;
                    w_op_b_next  = bus.b;
                    w_carry_next = 1'b0;
                    w_cnt_next   = '0;
                    w_state_next = StAdd;
                end
            end
            StAdd: begin
                w_sum_next[r_cnt] = w_slice[SLICE-1:0];
                w_carry_next      = w_slice[SLICE];
                if (w_last) begin
                    // Signed overflow: operands agree in sign but the result does not.
                    w_cout_next  = w_slice[SLICE];
                    w_ovf_next   = (r_op_a[N-1][SLICE-1] == r_op_b[N-1][SLICE-1]) &&
                                   (w_slice[SLICE-1] != r_op_a[N-1][SLICE-1]);
                    w_state_next = StDone;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            StDone: begin
                w_state_next = StHold;
            end
            StHold: begin
                // Wait for run to drop so that one press gives exactly one add.
                if (!bus.run) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_op_a  <= w_op_a_next;
            r_op_b  <= w_op_b_next;
            r_sum   <= w_sum_next;
            r_cnt   <= w_cnt_next;
            r_carry <= w_carry_next;
            r_cout  <= w_cout_next;
            r_ovf   <= w_ovf_next;
        end
    end

    assign bus.sum  = r_sum;
    assign bus.load = (r_state == StDone);
    assign bus.busy = (r_state == StAdd) || (r_state == StDone);
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: table vectors, random operations against a full-width add model,
// and hand-written reset sequences.
module tb_nibble_serial_adder;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned SLICE = 4;
    localparam int          N     = WIDTH / SLICE;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;

    nibble_serial_adder_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_adder #(
        .WIDTH(WIDTH),
        .SLICE(SLICE)
    ) u_dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          hold;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {ovf, cout, sum} of a plain full-width add.
    function automatic logic [17:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] t;
        logic        o;
        t = {1'b0, a} + {1'b0, b};
        o = (a[15] == b[15]) && (t[15] != a[15]);
        return {o, t};
    endfunction

    // Run high for 'hold' capture edges; operands are scrambled after capture.
    // The loop ends so that the next call captures exactly N+3 edges later.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold,
                          input logic [15:0] e_sum, input logic e_cout, input logic e_ovf,
                          input string tag);
        logic [15:0] got_sum;
        logic        got_c;
        logic        got_o;
        int          loads;
        bus.a   = a;
        bus.b   = b;
        bus.run = 1'b1;
        loads   = 0;
        got_sum = '0;
        got_c   = 1'b0;
        got_o   = 1'b0;
        for (int i = 0; i <= hold + N + 1; i++) begin
            @(posedge clk);
            #1;
            bus.a = 16'($urandom);
            bus.b = 16'($urandom);
            check({tag, " load"}, 32'(bus.load), 32'(i == N));
            check({tag, " busy"}, 32'(bus.busy), 32'(i <= N));
            if (bus.load) begin
                loads++;
                got_sum = bus.sum;
                got_c   = bus.cout;
                got_o   = bus.ovf;
            end
            if (i + 1 >= hold) bus.run = 1'b0;
        end
        check({tag, " load count"}, 32'(loads), 32'd1);
        check({tag, " sum"}, 32'(got_sum), 32'(e_sum));
        check({tag, " cout"}, 32'(got_c), 32'(e_cout));
        check({tag, " ovf"}, 32'(got_o), 32'(e_ovf));
        check({tag, " sum held"}, 32'(bus.sum), 32'(e_sum));
    endtask

    vec_t vecs[6];

    initial begin
        logic [17:0] m;
        logic [15:0] ra, rb;
        n_vec   = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        bus.run = 1'b1;
        bus.a   = 16'h1234;
        bus.b   = 16'h4321;

        vecs[0] = '{16'h1234, 16'h4321, 1,  16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1,  16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 2,  16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0F0F, 16'h00F1, 20, 16'h1000, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 1,  16'h0000, 1'b1, 1'b1};
        vecs[5] = '{16'h0001, 16'h0001, 1,  16'h0002, 1'b0, 1'b0};

        // Reset held with run asserted: everything stays cleared.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset sum", 32'(bus.sum), 32'h0);
            check("reset load", 32'(bus.load), 32'h0);
            check("reset cout", 32'(bus.cout), 32'h0);
            check("reset ovf", 32'(bus.ovf), 32'h0);
            check("reset busy", 32'(bus.busy), 32'h0);
        end
        bus.run = 1'b0;
        rst_n   = 1'b1;
        @(posedge clk);
        #1;
        check("idle busy", 32'(bus.busy), 32'h0);

        foreach (vecs[v]) begin
            run_op(vecs[v].a, vecs[v].b, vecs[v].hold, vecs[v].sum, vecs[v].cout, vecs[v].ovf,
                   $sformatf("vec%0d", v));
        end

        for (int r = 0; r < 40; r++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (r % 8 == 0) ra = 16'hFFFF;
            if (r % 8 == 1) rb = 16'h8000;
            m = ref_add(ra, rb);
            run_op(ra, rb, int'($urandom_range(1, 6)), m[15:0], m[16], m[17],
                   $sformatf("rnd%0d", r));
        end

        // Leave nonzero results behind, then abort an operation with reset mid-ADD.
        run_op(16'hFFFF, 16'hFFFF, 1, 16'hFFFE, 1'b1, 1'b0, "pre-abort");
        bus.a   = 16'h0F0F;
        bus.b   = 16'hF0F0;
        bus.run = 1'b1;
        @(posedge clk);
        #1;
        bus.run = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort sum", 32'(bus.sum), 32'h0);
        check("abort cout", 32'(bus.cout), 32'h0);
        check("abort ovf", 32'(bus.ovf), 32'h0);
        check("abort busy", 32'(bus.busy), 32'h0);
        check("abort load", 32'(bus.load), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("post-abort load", 32'(bus.load), 32'h0);
            check("post-abort busy", 32'(bus.busy), 32'h0);
        end
        run_op(16'h0001, 16'h0002, 1, 16'h0003, 1'b0, 1'b0, "after-abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: bench still running at 1 ms, expected completion");
        $fatal(1);
    end
endmodule
